// File: rtl/tap_pkg.sv
// Shared JTAG TAP definitions: IEEE 1149.1 state encoding, the TAP transition
// function and the driver FSM states.
package tap_pkg;

  localparam int TAP_W = 4;

  typedef enum logic [TAP_W-1:0] {
    TAP_EX2DR   = 4'h0,
    TAP_EX1DR   = 4'h1,
    TAP_SHDR    = 4'h2,
    TAP_PAUSEDR = 4'h3,
    TAP_SELIR   = 4'h4,
    TAP_UPDDR   = 4'h5,
    TAP_CAPDR   = 4'h6,
    TAP_SELDR   = 4'h7,
    TAP_EX2IR   = 4'h8,
    TAP_EX1IR   = 4'h9,
    TAP_SHIR    = 4'hA,
    TAP_PAUSEIR = 4'hB,
    TAP_RTI     = 4'hC,
    TAP_UPDIR   = 4'hD,
    TAP_CAPIR   = 4'hE,
    TAP_TLR     = 4'hF
  } tap_state_t;

  typedef enum logic [1:0] {
    DRV_SYNC,
    DRV_IDLE,
    DRV_WALK,
    DRV_RESET
  } drv_state_t;

  function automatic tap_state_t tap_next_state(input tap_state_t s, input logic tms);
    tap_state_t n;
    n = TAP_TLR;
    case (s)
      TAP_TLR:     n = tms ? TAP_TLR   : TAP_RTI;
      TAP_RTI:     n = tms ? TAP_SELDR : TAP_RTI;
      TAP_SELDR:   n = tms ? TAP_SELIR : TAP_CAPDR;
      TAP_CAPDR:   n = tms ? TAP_EX1DR : TAP_SHDR;
      TAP_SHDR:    n = tms ? TAP_EX1DR : TAP_SHDR;
      TAP_EX1DR:   n = tms ? TAP_UPDDR : TAP_PAUSEDR;
      TAP_PAUSEDR: n = tms ? TAP_EX2DR : TAP_PAUSEDR;
      TAP_EX2DR:   n = tms ? TAP_UPDDR : TAP_SHDR;
      TAP_UPDDR:   n = tms ? TAP_SELDR : TAP_RTI;
      TAP_SELIR:   n = tms ? TAP_TLR   : TAP_CAPIR;
      TAP_CAPIR:   n = tms ? TAP_EX1IR : TAP_SHIR;
      TAP_SHIR:    n = tms ? TAP_EX1IR : TAP_SHIR;
      TAP_EX1IR:   n = tms ? TAP_UPDIR : TAP_PAUSEIR;
      TAP_PAUSEIR: n = tms ? TAP_EX2IR : TAP_PAUSEIR;
      TAP_EX2IR:   n = tms ? TAP_UPDIR : TAP_SHIR;
      TAP_UPDIR:   n = tms ? TAP_SELDR : TAP_RTI;
      default:     n = TAP_TLR;
    endcase
    return n;
  endfunction

  function automatic logic tap_is_stable(input tap_state_t s);
    return s inside {TAP_TLR, TAP_RTI, TAP_SHDR, TAP_PAUSEDR, TAP_SHIR, TAP_PAUSEIR};
  endfunction

endpackage

// File: rtl/tap_route_rom.sv
// First-hop TMS of the shortest TAP path from any state to a stable target.
// Each target lists the states whose shortest path starts with TMS=0.
module tap_route_rom
  import tap_pkg::*;
(
  input  logic [TAP_W-1:0] cur_i,
  input  logic [TAP_W-1:0] target_i,
  output logic             tms_o
);

  tap_state_t cur;
  tap_state_t tgt;

  assign cur = tap_state_t'(cur_i);
  assign tgt = tap_state_t'(target_i);

  // Non-stable targets are never walked to; TMS=1 is the safe value there.
  always_comb begin
    tms_o = 1'b1;
    case (tgt)
      TAP_TLR:     tms_o = 1'b1;
      TAP_RTI:     tms_o = !(cur inside {TAP_TLR, TAP_RTI, TAP_UPDDR, TAP_UPDIR});
      TAP_SHDR:    tms_o = !(cur inside {TAP_TLR, TAP_SELDR, TAP_CAPDR, TAP_SHDR,
                                         TAP_EX1DR, TAP_EX2DR});
      TAP_PAUSEDR: tms_o = !(cur inside {TAP_TLR, TAP_SELDR, TAP_EX1DR, TAP_PAUSEDR,
                                         TAP_EX2DR});
      TAP_SHIR:    tms_o = !(cur inside {TAP_TLR, TAP_SELIR, TAP_CAPIR, TAP_SHIR,
                                         TAP_EX1IR, TAP_EX2IR});
      TAP_PAUSEIR: tms_o = !(cur inside {TAP_TLR, TAP_SELIR, TAP_EX1IR, TAP_PAUSEIR,
                                         TAP_EX2IR});
      default:     tms_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/tap_tms_driver.sv
// JTAG TAP initiator: walks the TAP to a requested stable state, keeps a shadow
// of the TAP state, pulses TRST on command and checks the TAP's observed state.
module tap_tms_driver
  import tap_pkg::*;
#(
  parameter int SYNC_LEN    = 5,
  parameter int TRST_CYCLES = 1
) (
  input  logic             GCLK,
  input  logic             RST,
  // req_valid/req_ready: a request transfers on any GCLK edge where both are 1.
  input  logic             req_valid,
  input  logic [TAP_W-1:0] req_state,
  output logic             req_ready,
  input  logic             trst_req,
  input  logic             obs_valid,
  input  logic [TAP_W-1:0] obs_state,
  output logic             TMS,
  output logic             TRST,
  output logic [TAP_W-1:0] cur_state,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             abort,
  output logic             mismatch,
  output logic [1:0]       dbg_state
);

  localparam logic [2:0] SYNC_LAST = 3'(SYNC_LEN - 1);
  localparam logic [3:0] TRST_LAST = 4'(TRST_CYCLES - 1);

  drv_state_t state_q, state_d;
  tap_state_t cur_q, cur_d;
  tap_state_t target_q, target_d;
  logic       tms_q, tms_d;
  logic       trst_q, trst_d;
  logic [2:0] sync_cnt_q, sync_cnt_d;
  logic [3:0] trst_cnt_q, trst_cnt_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       abort_q, abort_d;
  logic       mismatch_q, mismatch_d;

  tap_state_t req_tap;
  tap_state_t walk_next;
  tap_state_t rom_cur;
  tap_state_t rom_tgt;
  logic       accept;
  logic       req_stable;
  logic       rom_tms;

  assign req_tap    = tap_state_t'(req_state);
  assign walk_next  = tap_next_state(cur_q, tms_q);
  assign accept     = (state_q == DRV_IDLE) && req_valid && !trst_req;
  assign req_stable = tap_is_stable(req_tap);

  // In WALK the ROM looks one hop ahead, since TMS is registered alongside the shadow.
  assign rom_cur = (state_q == DRV_WALK) ? walk_next : cur_q;
  assign rom_tgt = (state_q == DRV_WALK) ? target_q :
                   ((accept && req_stable) ? req_tap : cur_q);

  tap_route_rom u_rom (
    .cur_i   (rom_cur),
    .target_i(rom_tgt),
    .tms_o   (rom_tms)
  );

  always_ff @(posedge GCLK or posedge RST) begin
    if (RST) begin
      state_q    <= DRV_SYNC;
      cur_q      <= TAP_TLR;
      target_q   <= TAP_TLR;
      tms_q      <= 1'b1;
      trst_q     <= 1'b0;
      sync_cnt_q <= '0;
      trst_cnt_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      abort_q    <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      target_q   <= target_d;
      tms_q      <= tms_d;
      trst_q     <= trst_d;
      sync_cnt_q <= sync_cnt_d;
      trst_cnt_q <= trst_cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      abort_q    <= abort_d;
      mismatch_q <= mismatch_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    target_d   = target_q;
    tms_d      = tms_q;
    trst_d     = 1'b0;
    sync_cnt_d = sync_cnt_q;
    trst_cnt_d = trst_cnt_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    abort_d    = 1'b0;
    mismatch_d = mismatch_q | (obs_valid && (obs_state != cur_q));

    if (trst_req) begin
      state_d    = DRV_RESET;
      cur_d      = TAP_TLR;
      tms_d      = 1'b1;
      trst_d     = 1'b1;
      trst_cnt_d = '0;
      mismatch_d = 1'b0;
      abort_d    = (state_q == DRV_WALK);
    end else begin
      case (state_q)
        DRV_SYNC: begin
          tms_d      = 1'b1;
          cur_d      = TAP_TLR;
          sync_cnt_d = sync_cnt_q + 3'd1;
          if (sync_cnt_q == SYNC_LAST) state_d = DRV_IDLE;
        end
        DRV_IDLE: begin
          tms_d = rom_tms;
          if (accept) begin
            if (!req_stable) begin
              err_d = 1'b1;
            end else if (req_tap == cur_q) begin
              done_d = 1'b1;
            end else begin
              target_d = req_tap;
              state_d  = DRV_WALK;
            end
          end
        end
        DRV_WALK: begin
          cur_d = walk_next;
          tms_d = rom_tms;
          if (walk_next == target_q) begin
            done_d  = 1'b1;
            state_d = DRV_IDLE;
          end
        end
        DRV_RESET: begin
          tms_d      = 1'b1;
          cur_d      = TAP_TLR;
          trst_cnt_d = trst_cnt_q + 4'd1;
          if (trst_cnt_q == TRST_LAST) state_d = DRV_IDLE;
          else trst_d = 1'b1;
        end
        default: state_d = DRV_SYNC;
      endcase
    end
  end

  assign req_ready = (state_q == DRV_IDLE) && !trst_req;
  assign TMS       = tms_q;
  assign TRST      = trst_q;
  assign cur_state = cur_q;
  assign busy      = (state_q != DRV_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign abort     = abort_q;
  assign mismatch  = mismatch_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tap_tms_driver.sv
// Bench for tap_tms_driver: table of walk requests with hand-derived TMS paths,
// plus hand-written sequences for reset, abort, TRST collisions and mismatch.
module tb_tap_tms_driver;

  localparam int SYNC_LEN    = 5;
  localparam int TRST_CYCLES = 2;
  localparam int W           = 1;

  logic       GCLK = 1'b0;
  logic       RST;
  logic       req_valid;
  logic [3:0] req_state;
  logic       req_ready;
  logic       trst_req;
  logic       obs_valid;
  logic [3:0] obs_state;
  logic       TMS;
  logic       TRST;
  logic [3:0] cur_state;
  logic       busy;
  logic       done;
  logic       err;
  logic       abort;
  logic       mismatch;
  logic [1:0] dbg_state;

  always #5 GCLK = ~GCLK;

  tap_tms_driver #(.SYNC_LEN(SYNC_LEN), .TRST_CYCLES(TRST_CYCLES)) dut (
    .GCLK     (GCLK),
    .RST      (RST),
    .req_valid(req_valid),
    .req_state(req_state),
    .req_ready(req_ready),
    .trst_req (trst_req),
    .obs_valid(obs_valid),
    .obs_state(obs_state),
    .TMS      (TMS),
    .TRST     (TRST),
    .cur_state(cur_state),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .abort    (abort),
    .mismatch (mismatch),
    .dbg_state(dbg_state)
  );

  // seq holds the path MSB-first: hop 0 is seq[hops-1].
  typedef struct {
    logic [3:0] target;
    int         hops;
    logic [7:0] seq;
    logic       bad;
  } vec_t;

  vec_t       vecs[16];
  logic [W-1:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] model_state;

  task automatic step();
    @(posedge GCLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    while (!req_ready && n < budget) begin
      step();
      n++;
    end
    chk("ready_timeout", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic wait_trst_done();
    for (int i = 1; i < TRST_CYCLES; i++) begin
      step();
      chk("trst_held", {31'd0, TRST}, 32'd1);
      chk("trst_no_done", {31'd0, done}, 32'd0);
    end
    step();
    chk("trst_released", {31'd0, TRST}, 32'd0);
    chk("trst_idle", {31'd0, busy}, 32'd0);
    chk("trst_cur_tlr", {28'd0, cur_state}, 32'hF);
    chk("trst_tms_hold", {31'd0, TMS}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    logic hold;
    wait_ready(40);
    hold = (model_state == 4'hF);
    req_valid = 1'b1;
    req_state = v.target;
    if (v.bad || v.target == model_state) exp_q.push_back(hold);
    else for (int i = 0; i < v.hops; i++) exp_q.push_back(v.seq[v.hops-1-i]);
    step();
    req_valid = 1'b0;
    if (v.bad) begin
      chk("err_pulse", {31'd0, err}, 32'd1);
      chk("err_no_done", {31'd0, done}, 32'd0);
      chk("err_cur", {28'd0, cur_state}, {28'd0, model_state});
      chk("err_tms", {31'd0, TMS}, {31'd0, exp_q.pop_front()});
      chk("err_idle", {31'd0, busy}, 32'd0);
      step();
      chk("err_clear", {31'd0, err}, 32'd0);
    end else if (v.target == model_state) begin
      chk("same_done", {31'd0, done}, 32'd1);
      chk("same_tms", {31'd0, TMS}, {31'd0, exp_q.pop_front()});
      chk("same_idle", {31'd0, busy}, 32'd0);
      step();
      chk("same_done_clear", {31'd0, done}, 32'd0);
    end else begin
      for (int i = 0; i < v.hops; i++) begin
        chk("walk_tms", {31'd0, TMS}, {31'd0, exp_q.pop_front()});
        chk("walk_done_early", {31'd0, done}, 32'd0);
        chk("walk_busy", {31'd0, busy}, 32'd1);
        step();
      end
      model_state = v.target;
      chk("walk_done", {31'd0, done}, 32'd1);
      chk("walk_cur", {28'd0, cur_state}, {28'd0, v.target});
      chk("walk_ready", {31'd0, req_ready}, 32'd1);
      chk("walk_hold_tms", {31'd0, TMS}, {31'd0, model_state == 4'hF});
      step();
      chk("walk_done_clear", {31'd0, done}, 32'd0);
    end
  endtask

  initial begin
    vecs[0]  = '{4'hA, 5, 8'b01100, 1'b0};
    vecs[1]  = '{4'hB, 2, 8'b10,    1'b0};
    vecs[2]  = '{4'h2, 5, 8'b11100, 1'b0};
    vecs[3]  = '{4'hF, 5, 8'b11111, 1'b0};
    vecs[4]  = '{4'hC, 1, 8'b0,     1'b0};
    vecs[5]  = '{4'h3, 4, 8'b1010,  1'b0};
    vecs[6]  = '{4'h2, 2, 8'b10,    1'b0};
    vecs[7]  = '{4'h6, 0, 8'b0,     1'b1};
    vecs[8]  = '{4'h2, 0, 8'b0,     1'b0};
    vecs[9]  = '{4'hC, 3, 8'b110,   1'b0};
    vecs[10] = '{4'hA, 4, 8'b1100,  1'b0};
    vecs[11] = '{4'hC, 3, 8'b110,   1'b0};
    vecs[12] = '{4'hB, 5, 8'b11010, 1'b0};
    vecs[13] = '{4'hF, 5, 8'b11111, 1'b0};
    vecs[14] = '{4'h1, 0, 8'b0,     1'b1};
    vecs[15] = '{4'hF, 0, 8'b0,     1'b0};

    RST = 1'b1; req_valid = 1'b0; req_state = 4'h0; trst_req = 1'b0;
    obs_valid = 1'b0; obs_state = 4'h0;
    model_state = 4'hF;

    // Reset values and SYNC window
    step(); step();
    chk("rst_tms", {31'd0, TMS}, 32'd1);
    chk("rst_trst", {31'd0, TRST}, 32'd0);
    chk("rst_cur", {28'd0, cur_state}, 32'hF);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_pulses", {29'd0, done, err, abort}, 32'd0);
    chk("rst_mismatch", {31'd0, mismatch}, 32'd0);
    RST = 1'b0;
    for (int i = 1; i < SYNC_LEN; i++) begin
      step();
      chk("sync_ready", {31'd0, req_ready}, 32'd0);
      chk("sync_tms", {31'd0, TMS}, 32'd1);
    end
    step();
    chk("sync_end_ready", {31'd0, req_ready}, 32'd1);
    chk("sync_end_busy", {31'd0, busy}, 32'd0);
    chk("sync_end_cur", {28'd0, cur_state}, 32'hF);
    chk("sync_end_tms", {31'd0, TMS}, 32'd1);

    for (int i = 0; i < 16; i++) run_vec(vecs[i]);

    // TLR -> PauseDR killed by trst_req on the second hop
    wait_ready(40);
    req_valid = 1'b1; req_state = 4'h3;
    step();
    req_valid = 1'b0;
    chk("abort_hop1", {31'd0, TMS}, 32'd0);
    step();
    chk("abort_hop2", {31'd0, TMS}, 32'd1);
    chk("abort_mid_cur", {28'd0, cur_state}, 32'hC);
    trst_req = 1'b1;
    step();
    trst_req = 1'b0;
    chk("abort_pulse", {31'd0, abort}, 32'd1);
    chk("abort_trst", {31'd0, TRST}, 32'd1);
    chk("abort_tms", {31'd0, TMS}, 32'd1);
    chk("abort_cur", {28'd0, cur_state}, 32'hF);
    chk("abort_no_done", {31'd0, done}, 32'd0);
    chk("abort_not_ready", {31'd0, req_ready}, 32'd0);
    step();
    chk("abort_pulse_clear", {31'd0, abort}, 32'd0);
    if (TRST_CYCLES > 1) begin
      chk("abort_trst2", {31'd0, TRST}, 32'd1);
      for (int i = 2; i < TRST_CYCLES; i++) step();
      step();
    end
    chk("abort_trst_end", {31'd0, TRST}, 32'd0);
    chk("abort_idle", {31'd0, busy}, 32'd0);
    chk("abort_end_no_done", {31'd0, done}, 32'd0);
    model_state = 4'hF;

    // trst_req and req_valid together: reset wins, request dropped
    req_valid = 1'b1; req_state = 4'hA; trst_req = 1'b1;
    #1;
    chk("simul_ready", {31'd0, req_ready}, 32'd0);
    step();
    req_valid = 1'b0; trst_req = 1'b0;
    chk("simul_busy", {31'd0, busy}, 32'd1);
    chk("simul_trst", {31'd0, TRST}, 32'd1);
    chk("simul_no_abort", {31'd0, abort}, 32'd0);
    wait_trst_done();
    step();
    chk("simul_no_walk", {28'd0, cur_state}, 32'hF);

    // Mismatch: valid gating, sticky set, cleared by RESET entry
    obs_valid = 1'b1; obs_state = 4'hF;
    step();
    chk("obs_match", {31'd0, mismatch}, 32'd0);
    obs_valid = 1'b0; obs_state = 4'hC;
    step();
    chk("obs_gated", {31'd0, mismatch}, 32'd0);
    obs_valid = 1'b1;
    step();
    obs_valid = 1'b0;
    chk("obs_mismatch", {31'd0, mismatch}, 32'd1);
    step(); step();
    chk("obs_sticky", {31'd0, mismatch}, 32'd1);
    trst_req = 1'b1;
    step();
    trst_req = 1'b0;
    chk("obs_cleared", {31'd0, mismatch}, 32'd0);
    wait_trst_done();

    // Asynchronous RST in the middle of a walk
    wait_ready(40);
    req_valid = 1'b1; req_state = 4'hA;
    step();
    req_valid = 1'b0;
    step();
    RST = 1'b1;
    #1;
    chk("async_rst_busy", {31'd0, busy}, 32'd1);
    chk("async_rst_cur", {28'd0, cur_state}, 32'hF);
    chk("async_rst_tms", {31'd0, TMS}, 32'd1);
    chk("async_rst_ready", {31'd0, req_ready}, 32'd0);
    step();
    RST = 1'b0;

    // trst_req during SYNC ends SYNC via RESET
    step(); step();
    trst_req = 1'b1;
    step();
    trst_req = 1'b0;
    chk("sync_trst", {31'd0, TRST}, 32'd1);
    chk("sync_trst_no_abort", {31'd0, abort}, 32'd0);
    wait_trst_done();
    model_state = 4'hF;
    run_vec(vecs[4]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tap_tms_driver.md
# tap_tms_driver

JTAG TAP initiator that drives TMS and TRST into the TAP_route controller so the TAP moves to a requested stable state along the shortest legal path. It keeps a shadow copy of the TAP state. It can also check that shadow against the TAP's 4-bit state observation outputs. It sits between the test sequencer logic and the TAP pads, replacing hand-written TMS stimulus.

## Interface
- SYNC_LEN, default 5: TMS=1 cycles issued after reset release to force Test-Logic-Reset.
- TRST_CYCLES, default 1: width of a TRST pulse in GCLK cycles (1..15).
- GCLK  in  1  single clock; TAP samples TMS on the same rising edge.
- RST  in  1  asynchronous, active-high reset.
- req_valid  in  1  walk request.
- req_state  in  4  target state, IEEE 1149.1 encoding.
- req_ready  out  1  request accepted on an edge with req_valid && req_ready.
- trst_req  in  1  single-cycle command to pulse TRST.
- obs_valid  in  1  obs_state is meaningful this cycle.
- obs_state  in  4  state_obs3..0 from the TAP.
- TMS  out  1  registered TMS to the TAP.
- TRST  out  1  registered TRST to the TAP, active-high.
- cur_state  out  4  shadow TAP state.
- busy  out  1  FSM not in IDLE.
- done  out  1  one-cycle pulse when the shadow reaches the target.
- err  out  1  one-cycle pulse when a request is rejected.
- abort  out  1  one-cycle pulse when a walk is killed by trst_req.
- mismatch  out  1  sticky flag: obs_state differed from cur_state.

## Operation
- State encoding, fixed:
  - TLR=F, RTI=C
  - SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5
  - SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D
- Stable targets: TLR, RTI, ShDR, PauseDR, ShIR, PauseIR. Any other req_state is accepted, pulses err for one cycle, and leaves the shadow unchanged.
- FSM states: SYNC, IDLE, WALK, RESET.
- SYNC:
  - Entered on reset release.
  - Drives TMS=1 for SYNC_LEN cycles, with req_ready=0.
  - Shadow is TLR throughout. Then goes to IDLE.
- IDLE:
  - req_ready=1.
  - TMS holds the current state: 1 in TLR, 0 in the other stable states.
  - A request with req_state==cur_state pulses done on the next cycle; TMS does not change.
- WALK:
  - Each cycle, TMS = next_tms(cur_state, target).
  - Each edge, the shadow advances by the TAP transition for the TMS value just presented.
  - When the shadow reaches the target: pulse done, go to IDLE.
  - Paths are shortest and unique for every stable pair. Maximum length is 5 (for example ShDR→TLR is 1,1,1,1,1).
- RESET:
  - Entered when trst_req is seen, from any state.
  - Drives TRST=1 and TMS=1 for TRST_CYCLES cycles.
  - Shadow is forced to TLR. Then goes to IDLE.
  - If this interrupted WALK, pulse abort and do not pulse done.
- Mismatch check:
  - Every edge with obs_valid=1, compare obs_state with cur_state as it stood before that edge.
  - On inequality, set mismatch.
  - mismatch clears only on RST or on entry to RESET.

## Timing
- Reset values: TMS=1, TRST=0, cur_state=F, req_ready=0, busy=1 (SYNC), done=0, err=0, abort=0, mismatch=0.
- Request accepted at edge k:
  - First hop TMS is registered at edge k.
  - Shadow updates at edge k+1.
  - An N-hop path pulses done in the cycle after edge k+N.
  - req_ready returns to 1 together with done.
- Simultaneous events:
  - trst_req and req_valid on the same edge: trst_req wins and the request is not accepted (req_ready is 0 on that edge).
  - trst_req during RESET restarts the TRST count.
  - trst_req during SYNC ends SYNC and enters RESET.
- RST mid-walk returns the block to SYNC asynchronously.

## Structure
- Package tap_pkg holds:
  - the 4-bit state constants and the tap_state_t typedef;
  - function tap_next_state(state, tms), the IEEE transition function;
  - function tap_is_stable(state).
- One sub-module, tap_route_rom: combinational 16×16 to 1-bit next_tms lookup, generated from the shortest-path rule.
- Counters:
  - 3-bit SYNC counter;
  - 4-bit TRST counter.

## Test plan
- Release reset → TMS=1 for 5 cycles, then req_ready=1 with cur_state=F and TMS=1.
- From TLR, request ShIR (A) → TMS sequence 0,1,1,0,0; done five cycles after acceptance; cur_state=A.
- From ShDR (2), request TLR (F) → TMS 1,1,1,1,1; then request RTI (C) → TMS 0, done.
- Request CapDR (6) → err pulse, cur_state unchanged, TMS unchanged; a request for the current state → done after one cycle with no TMS activity.
- trst_req on the second hop of a TLR→PauseDR walk → abort pulse, TRST=1 for TRST_CYCLES, cur_state=F, no done.
- Feed obs_state=C while cur_state=F with obs_valid=1 → mismatch=1 and it stays set; trst_req clears it.
